// File: rtl/mips_exec_datapath.sv
// -----------------------------------------------------------------------------
// mips_exec_datapath
//
// Execute datapath for the multi-cycle MIPS bus CPU. It holds the 32x32
// register file, the ALU-control decoder and the 32-bit ALU. The CPU state
// machine sequences fetch/execute/memory/writeback and drives write_en,
// write_addr and wb_sel. Everything from instr to alu_out is combinational.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low register-file clear (0 = reset)
//   instr        current instruction word
//   write_en     register write enable (sampled at posedge clk)
//   write_addr   destination register (writes to $0 are dropped)
//   wb_sel       writeback source: 0 = alu_out, 1 = mem_data
//   mem_data     load data returned by the bus
//   rs_val       register[instr rs]   (combinational read)
//   rt_val       register[instr rt]   (combinational read)
//   alu_out      ALU result
//   alu_zero     alu_out == 0
//   illegal      opcode/funct not supported
//   register_v0  register 2 ($v0)
// -----------------------------------------------------------------------------
module mips_exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic        wb_sel,
  input  logic [31:0] mem_data,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  output logic        illegal,
  output logic [31:0] register_v0
);

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_PASS_A,
    OP_LUI,
    OP_ZERO
  } alu_op_e;

  typedef enum logic [1:0] {
    B_RT,
    B_SEXT,
    B_ZEXT
  } b_sel_e;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // ---------------------------------------------------------------------------
  // Register file: flop array so that reads can be combinational.
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [32];
  logic [31:0] wr_data_d;

  assign wr_data_d = wb_sel ? mem_data : alu_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_en && (write_addr != 5'd0)) begin
      regs_q[write_addr] <= wr_data_d;
    end
  end

  // $0 is masked on read so it is 0 even before the first reset.
  assign rs_val      = (rs_idx == 5'd0) ? 32'd0 : regs_q[rs_idx];
  assign rt_val      = (rt_idx == 5'd0) ? 32'd0 : regs_q[rt_idx];
  assign register_v0 = regs_q[2];

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  alu_op_e alu_op;
  b_sel_e  b_sel;
  logic    shift_var;   // 1: shift amount from rs[4:0], 0: from shamt field
  logic    is_illegal;

  always_comb begin
    alu_op     = OP_ZERO;
    b_sel      = B_RT;
    shift_var  = 1'b0;
    is_illegal = 1'b0;
    if (opcode == 6'h00) begin
      unique case (funct)
        6'h21:   alu_op = OP_ADD;
        6'h23:   alu_op = OP_SUB;
        6'h24:   alu_op = OP_AND;
        6'h25:   alu_op = OP_OR;
        6'h26:   alu_op = OP_XOR;
        6'h27:   alu_op = OP_NOR;
        6'h2A:   alu_op = OP_SLT;
        6'h2B:   alu_op = OP_SLTU;
        6'h00:   alu_op = OP_SLL;
        6'h02:   alu_op = OP_SRL;
        6'h03:   alu_op = OP_SRA;
        6'h04: begin alu_op = OP_SLL; shift_var = 1'b1; end
        6'h06: begin alu_op = OP_SRL; shift_var = 1'b1; end
        6'h07: begin alu_op = OP_SRA; shift_var = 1'b1; end
        6'h08,
        6'h09:   alu_op = OP_PASS_A;   // JR/JALR: jump target is rs
        default: is_illegal = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        6'h09: begin alu_op = OP_ADD;  b_sel = B_SEXT; end
        6'h0A: begin alu_op = OP_SLT;  b_sel = B_SEXT; end
        // SLTIU still sign-extends, then compares unsigned
        6'h0B: begin alu_op = OP_SLTU; b_sel = B_SEXT; end
        // Loads and stores: effective address rs + sext(imm)
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
          alu_op = OP_ADD;
          b_sel  = B_SEXT;
        end
        6'h0C: begin alu_op = OP_AND; b_sel = B_ZEXT; end
        6'h0D: begin alu_op = OP_OR;  b_sel = B_ZEXT; end
        6'h0E: begin alu_op = OP_XOR; b_sel = B_ZEXT; end
        6'h0F:   alu_op = OP_LUI;
        6'h02,
        6'h03:   alu_op = OP_ZERO;     // J/JAL: target formed elsewhere
        default: is_illegal = 1'b1;
      endcase
    end
  end

  assign illegal = is_illegal;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] op_b;
  logic [4:0]  sh_amt;
  logic [31:0] alu_res;

  always_comb begin
    unique case (b_sel)
      B_SEXT:  op_b = {{16{imm[15]}}, imm};
      B_ZEXT:  op_b = {16'd0, imm};
      default: op_b = rt_val;
    endcase
  end

  assign sh_amt = shift_var ? rs_val[4:0] : shamt;

  always_comb begin
    alu_res = 32'd0;
    unique case (alu_op)
      OP_ADD:    alu_res = rs_val + op_b;
      OP_SUB:    alu_res = rs_val - op_b;
      OP_AND:    alu_res = rs_val & op_b;
      OP_OR:     alu_res = rs_val | op_b;
      OP_XOR:    alu_res = rs_val ^ op_b;
      OP_NOR:    alu_res = ~(rs_val | op_b);
      OP_SLT:    alu_res = {31'd0, $signed(rs_val) < $signed(op_b)};
      OP_SLTU:   alu_res = {31'd0, rs_val < op_b};
      OP_SLL:    alu_res = op_b << sh_amt;
      OP_SRL:    alu_res = op_b >> sh_amt;
      OP_SRA:    alu_res = $signed(op_b) >>> sh_amt;
      OP_PASS_A: alu_res = rs_val;
      OP_LUI:    alu_res = {imm, 16'd0};
      default:   alu_res = 32'd0;
    endcase
  end

  assign alu_out  = alu_res;
  assign alu_zero = (alu_res == 32'd0);

endmodule

// File: tb/tb_mips_exec_datapath.sv
// -----------------------------------------------------------------------------
// tb_mips_exec_datapath
//
// Directed steps from the test plan followed by randomized instructions, all
// checked against a shadow register array and an instruction-level reference
// function.
// -----------------------------------------------------------------------------
module tb_mips_exec_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        write_en;
  logic [4:0]  write_addr;
  logic        wb_sel;
  logic [31:0] mem_data;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        illegal;
  logic [31:0] register_v0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_regs [32];

  always #5 clk = ~clk;

  mips_exec_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .write_en   (write_en),
    .write_addr (write_addr),
    .wb_sel     (wb_sel),
    .mem_data   (mem_data),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .illegal    (illegal),
    .register_v0(register_v0)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, 5'd0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Reference: returns {illegal, result} from the instruction and operand values.
  function automatic logic [32:0] ref_exec(input logic [31:0] ins,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [31:0] zx;
    int          sh;
    int          shv;
    op  = ins[31:26];
    fn  = ins[5:0];
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'd0, ins[15:0]};
    sh  = int'(ins[10:6]);
    shv = int'(a) & 31;
    if (op == 6'h00) begin
      case (fn)
        6'h21: return {1'b0, a + b};
        6'h23: return {1'b0, a - b};
        6'h24: return {1'b0, a & b};
        6'h25: return {1'b0, a | b};
        6'h26: return {1'b0, a ^ b};
        6'h27: return {1'b0, ~(a | b)};
        6'h2A: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
        6'h2B: return {1'b0, (a < b) ? 32'd1 : 32'd0};
        6'h00: return {1'b0, b << sh};
        6'h02: return {1'b0, b >> sh};
        6'h03: return {1'b0, 32'($signed(b) >>> sh)};
        6'h04: return {1'b0, b << shv};
        6'h06: return {1'b0, b >> shv};
        6'h07: return {1'b0, 32'($signed(b) >>> shv)};
        6'h08, 6'h09: return {1'b0, a};
        default: return {1'b1, 32'd0};
      endcase
    end
    case (op)
      6'h09: return {1'b0, a + sx};
      6'h0A: return {1'b0, ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0};
      6'h0B: return {1'b0, (a < sx) ? 32'd1 : 32'd0};
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: return {1'b0, a + sx};
      6'h0C: return {1'b0, a & zx};
      6'h0D: return {1'b0, a | zx};
      6'h0E: return {1'b0, a ^ zx};
      6'h0F: return {1'b0, ins[15:0], 16'd0};
      6'h02, 6'h03: return {1'b0, 32'd0};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic ws, input logic [31:0] md);
    instr      = ins;
    write_en   = we;
    write_addr = wa;
    wb_sel     = ws;
    mem_data   = md;
    #1;
  endtask

  // Advance one clock edge and update the shadow register file.
  task automatic tick();
    logic [32:0] r;
    logic [31:0] wd;
    r  = ref_exec(instr, model_regs[instr[25:21]], model_regs[instr[20:16]]);
    wd = wb_sel ? mem_data : r[31:0];
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (write_en && (write_addr != 5'd0)) begin
      model_regs[write_addr] = wd;
    end
    #1;
  endtask

  task automatic read_reg(input string tag, input logic [4:0] n, input logic [31:0] exp);
    drive(rtype(n, 5'd0, 5'd0, 6'h21), 1'b0, 5'd0, 1'b0, 32'd0);
    chk(tag, rs_val, exp);
  endtask

  task automatic check_all(input string tag);
    logic [32:0] r;
    r = ref_exec(instr, model_regs[instr[25:21]], model_regs[instr[20:16]]);
    chk({tag, "_rs"},  rs_val, model_regs[instr[25:21]]);
    chk({tag, "_rt"},  rt_val, model_regs[instr[20:16]]);
    chk({tag, "_alu"}, alu_out, r[31:0]);
    chk({tag, "_zero"}, {31'd0, alu_zero}, {31'd0, r[31:0] == 32'd0});
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, r[32]});
    chk({tag, "_v0"},  register_v0, model_regs[2]);
  endtask

  logic [5:0] rfuncts [16];
  logic [5:0] iops    [19];

  initial begin
    rfuncts = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
    iops    = '{6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h20, 6'h24, 6'h21, 6'h25,
                6'h28, 6'h29, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h03, 6'h3F, 6'h11};
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    // Reset with a pending write to $5: nothing is written, all reads 0.
    reset = 1'b0;
    drive(itype(6'h09, 5'd0, 5'd5, 16'h0007), 1'b1, 5'd5, 1'b0, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) read_reg("reset_read", 5'(i), 32'd0);
    chk("reset_v0", register_v0, 32'd0);

    // ADDIU $2,$0,0xFFFF
    drive(32'h2402FFFF, 1'b1, 5'd2, 1'b0, 32'd0);
    chk("addiu_alu", alu_out, 32'hFFFFFFFF);
    tick();
    chk("addiu_v0", register_v0, 32'hFFFFFFFF);

    // ORI $3,$0,0xFFFF
    drive(32'h3403FFFF, 1'b1, 5'd3, 1'b0, 32'd0);
    tick();
    read_reg("ori_r3", 5'd3, 32'h0000FFFF);

    // $4 = 0x80000000, $5 = 1
    drive(itype(6'h0F, 5'd0, 5'd4, 16'h8000), 1'b1, 5'd4, 1'b0, 32'd0);
    tick();
    drive(itype(6'h09, 5'd0, 5'd5, 16'h0001), 1'b1, 5'd5, 1'b0, 32'd0);
    tick();
    drive(rtype(5'd4, 5'd5, 5'd0, 6'h21), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("addu", alu_out, 32'h80000001);
    drive(rtype(5'd4, 5'd5, 5'd0, 6'h23), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("subu", alu_out, 32'h7FFFFFFF);
    drive(rtype(5'd4, 5'd5, 5'd0, 6'h2A), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("slt", alu_out, 32'd1);
    drive(rtype(5'd4, 5'd5, 5'd0, 6'h2B), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("sltu", alu_out, 32'd0);
    drive(rtype(5'd2, 5'd5, 5'd0, 6'h21), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("addu_wrap", alu_out, 32'd0);
    chk("addu_wrap_zero", {31'd0, alu_zero}, 32'd1);

    // Shifts: $6 = 0xF0000000, $7 = 33
    drive(itype(6'h0F, 5'd0, 5'd6, 16'hF000), 1'b1, 5'd6, 1'b0, 32'd0);
    tick();
    drive(rtype(5'd0, 5'd6, 5'd4, 6'h03), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("sra", alu_out, 32'hFF000000);
    drive(rtype(5'd0, 5'd6, 5'd4, 6'h02), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("srl", alu_out, 32'h0F000000);
    drive(itype(6'h09, 5'd0, 5'd7, 16'd33), 1'b1, 5'd7, 1'b0, 32'd0);
    tick();
    drive(rtype(5'd7, 5'd5, 5'd0, 6'h04), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("sllv_33", alu_out, 32'd2);

    // Write to $0 is dropped
    drive(rtype(5'd0, 5'd0, 5'd0, 6'h21), 1'b1, 5'd0, 1'b1, 32'hDEADBEEF);
    tick();
    read_reg("r0_write", 5'd0, 32'd0);

    // Read during write sees the old value, new value after the edge
    drive(rtype(5'd8, 5'd0, 5'd0, 6'h21), 1'b1, 5'd8, 1'b1, 32'h11111111);
    chk("rdw_old", rs_val, 32'd0);
    tick();
    chk("rdw_new", rs_val, 32'h11111111);

    // LW address and load writeback
    drive(itype(6'h09, 5'd0, 5'd9, 16'h0100), 1'b1, 5'd9, 1'b0, 32'd0);
    tick();
    drive(itype(6'h23, 5'd9, 5'd10, 16'hFFFC), 1'b1, 5'd10, 1'b1, 32'h12345678);
    chk("lw_addr", alu_out, 32'h000000FC);
    tick();
    read_reg("lw_wb", 5'd10, 32'h12345678);

    // Illegal opcode, J, JR
    drive(itype(6'h3F, 5'd9, 5'd10, 16'h1234), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_alu", alu_out, 32'd0);
    drive(itype(6'h02, 5'd9, 5'd10, 16'h1234), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("j_flag", {31'd0, illegal}, 32'd0);
    chk("j_alu", alu_out, 32'd0);
    drive(rtype(5'd9, 5'd0, 5'd0, 6'h08), 1'b0, 5'd0, 1'b0, 32'd0);
    chk("jr_alu", alu_out, 32'h00000100);

    // Mid-operation reset wins over a write
    reset = 1'b0;
    drive(itype(6'h09, 5'd0, 5'd2, 16'h0055), 1'b1, 5'd2, 1'b0, 32'd0);
    tick();
    reset = 1'b1;
    read_reg("midrst_r9", 5'd9, 32'd0);
    chk("midrst_v0", register_v0, 32'd0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      int          pick;
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      ins = $urandom;
      else if (pick == 1) ins = rtype(5'($urandom), 5'($urandom), 5'($urandom),
                                      rfuncts[$urandom_range(0, 15)]);
      else                ins = itype(iops[$urandom_range(0, 18)], 5'($urandom),
                                      5'($urandom), 16'($urandom));
      reset = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      drive(ins, ($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), $urandom);
      check_all("rand");
      tick();
    end
    reset = 1'b1;
    drive(rtype(5'd2, 5'd3, 5'd0, 6'h21), 1'b0, 5'd0, 1'b0, 32'd0);
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
